// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM states, port count.
// No logic here; imported by the interface, the grant picker and the top.
// Opcode meanings belong to the external ALU and are listed only for requesters.
package alu_pkg;

    localparam int ALU_ARB_PORTS = 2;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_AND = 4'd1;
    localparam logic [3:0] ALU_OP_OR  = 4'd2;
    localparam logic [3:0] ALU_OP_EQ  = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between two requesters, the shared external ALU and the arbiter.
// slave is the arbiter's view; master is the requesters' and ALU's view.
// Request and response sides use valid/ready; the ALU side is purely combinational.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic [ALU_ARB_PORTS-1:0] req_valid;
    logic [ALU_ARB_PORTS-1:0] req_ready;
    logic [WIDTH-1:0]         req_r1_0;
    logic [WIDTH-1:0]         req_r2_0;
    logic [OPW-1:0]           req_op_0;
    logic [WIDTH-1:0]         req_r1_1;
    logic [WIDTH-1:0]         req_r2_1;
    logic [OPW-1:0]           req_op_1;

    logic [ALU_ARB_PORTS-1:0] resp_valid;
    logic [ALU_ARB_PORTS-1:0] resp_ready;
    logic [WIDTH-1:0]         resp_result;
    logic                     resp_zero;

    logic [WIDTH-1:0]         alu_r1;
    logic [WIDTH-1:0]         alu_r2;
    logic [OPW-1:0]           alu_op;
    logic [WIDTH-1:0]         alu_result;
    logic                     alu_zero;

    logic                     busy;

    modport slave (
        input  req_valid, req_r1_0, req_r2_0, req_op_0,
        input  req_r1_1, req_r2_1, req_op_1,
        input  resp_ready, alu_result, alu_zero,
        output req_ready, resp_valid, resp_result, resp_zero,
        output alu_r1, alu_r2, alu_op, busy
    );

    modport master (
        output req_valid, req_r1_0, req_r2_0, req_op_0,
        output req_r1_1, req_r2_1, req_op_1,
        output resp_ready, alu_result, alu_zero,
        input  req_ready, resp_valid, resp_result, resp_zero,
        input  alu_r1, alu_r2, alu_op, busy
    );

endinterface

// File: rtl/alu_arb_grant.sv
// Combinational 2-way picker: one-hot grant from the valid requests.
// Zero latency, no state. A lone valid requester always wins immediately.
// Ties: `ALU_ARB_ROUND_ROBIN_EN follows rr_ptr (1 = prefer port 1); otherwise port 0 wins.
module alu_arb_grant
    import alu_pkg::*;
(
    input  logic [ALU_ARB_PORTS-1:0] req_valid,
`ifdef ALU_ARB_ROUND_ROBIN_EN
    input  logic                     rr_ptr,
`endif
    output logic [ALU_ARB_PORTS-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
`else
            2'b11:   grant = 2'b01;
`endif
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external single-cycle ALU between two valid/ready requesters.
// Latency: result registered two edges after the request cycle; peak one op per 3 cycles.
// Backpressure: RESP holds until the granted port's resp_ready, and req_ready stays 0 meanwhile.
// `ALU_ARB_ROUND_ROBIN_EN selects round-robin ties; undefined gives fixed port 0 priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
)
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    arb_state_e               state_q;
    arb_state_e               state_d;
    logic [ALU_ARB_PORTS-1:0] grant;
    logic                     accept;
    logic                     gnt_q;
    logic [WIDTH-1:0]         r1_q;
    logic [WIDTH-1:0]         r2_q;
    logic [OPW-1:0]           op_q;
    logic [WIDTH-1:0]         res_q;
    logic                     zero_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Set means port 1 wins the next tie; reset value prefers port 0.
    logic rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (accept) begin
            rr_ptr_q <= grant[0];
        end
    end

    alu_arb_grant u_grant (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant)
    );
`else
    alu_arb_grant u_grant (
        .req_valid (bus.req_valid),
        .grant     (grant)
    );
`endif

    // req_ready equals the grant in IDLE, so any valid request is a handshake.
    assign accept = (state_q == IDLE) && (|bus.req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.busy       = (state_q != IDLE);
        case (state_q)
            IDLE:    bus.req_ready = grant;
            RESP:    bus.resp_valid[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    // Operand registers drive the ALU directly, so alu_* only change on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= 1'b0;
            r1_q   <= '0;
            r2_q   <= '0;
            op_q   <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                gnt_q <= grant[1];
                if (grant[1]) begin
                    r1_q <= bus.req_r1_1;
                    r2_q <= bus.req_r2_1;
                    op_q <= bus.req_op_1;
                end else begin
                    r1_q <= bus.req_r1_0;
                    r2_q <= bus.req_r2_0;
                    op_q <= bus.req_op_0;
                end
            end
            if (state_q == EXEC) begin
                res_q  <= bus.alu_result;
                zero_q <= bus.alu_zero;
            end
        end
    end

    assign bus.alu_r1      = r1_q;
    assign bus.alu_r2      = r2_q;
    assign bus.alu_op      = op_q;
    assign bus.resp_result = res_q;
    assign bus.resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with an external ALU model and a transaction-level reference.
// Honours `ALU_ARB_ROUND_ROBIN_EN for the expected tie-break rule.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int O = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    int   exp_pref = 0;
`endif

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .OPW(O)) bus ();

    alu_arbiter #(.WIDTH(W), .OPW(O)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] ref_alu(input logic [O-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            ALU_OP_ADD: return a + b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_EQ:  return (a == b) ? W'(1) : W'(0);
            default:    return '0;
        endcase
    endfunction

    // The shared ALU lives outside the arbiter; this is its model.
    assign bus.alu_result = ref_alu(bus.alu_op, bus.alu_r1, bus.alu_r2);
    assign bus.alu_zero   = (bus.alu_result == '0);

    function automatic logic [1:0] oh(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic int model_grant(input logic [1:0] mask);
        if (mask == 2'b10) return 1;
        if (mask == 2'b01) return 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        return exp_pref;
`else
        return 0;
`endif
    endfunction

    task automatic note_accept(input int g);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_pref = (g == 0) ? 1 : 0;
`else
        if (g < 0) $display("note: negative grant index");
`endif
    endtask

    task automatic idle_inputs();
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        bus.req_r1_0 = '0; bus.req_r2_0 = '0; bus.req_op_0 = '0;
        bus.req_r1_1 = '0; bus.req_r2_1 = '0; bus.req_op_1 = '0;
    endtask

    task automatic drive_port(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [O-1:0] op);
        if (p == 0) begin
            bus.req_r1_0 = a; bus.req_r2_0 = b; bus.req_op_0 = op;
        end else begin
            bus.req_r1_1 = a; bus.req_r2_1 = b; bus.req_op_1 = op;
        end
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One request on a single port, accepted and drained; returns what was observed.
    task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [O-1:0] op,
                        output bit ok, output logic [1:0] rdy, output logic [1:0] rv,
                        output logic [W-1:0] res, output logic z);
        @(posedge clk); #1;
        drive_port(p, a, b, op);
        bus.req_valid  = oh(p);
        bus.resp_ready = 2'b00;
        @(negedge clk);
        rdy = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        if (rdy != 2'b00) note_accept(p);
        wait_resp(ok);
        rv  = bus.resp_valid;
        res = bus.resp_result;
        z   = bus.resp_zero;
        bus.resp_ready = oh(p);
        @(posedge clk); #1;
        bus.resp_ready = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL %s req_ready got=%b exp=00", tag, bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 2'b00) begin n_bad++; $display("FAIL %s resp_valid got=%b exp=00", tag, bus.resp_valid); end
        n_cmp++; if (bus.resp_result !== '0) begin n_bad++; $display("FAIL %s resp_result got=%h exp=0", tag, bus.resp_result); end
        n_cmp++; if (bus.resp_zero !== 1'b0) begin n_bad++; $display("FAIL %s resp_zero got=%b exp=0", tag, bus.resp_zero); end
        n_cmp++; if ({bus.alu_r1, bus.alu_r2, bus.alu_op} !== '0) begin n_bad++; $display("FAIL %s alu_regs got=%h/%h/%h exp=0", tag, bus.alu_r1, bus.alu_r2, bus.alu_op); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy got=%b exp=0", tag, bus.busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_pref = 0;
`endif
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        drive_port(0, W'(5), W'(7), ALU_OP_ADD);
        bus.req_valid = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL add_req_ready got=%b exp=01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        note_accept(0);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL add_exec_busy got=%b exp=1", bus.busy); end
        n_cmp++; if (bus.alu_op !== ALU_OP_ADD || bus.alu_r1 !== W'(5) || bus.alu_r2 !== W'(7)) begin
            n_bad++; $display("FAIL add_exec_alu got=%h/%h/%h exp=5/7/0", bus.alu_r1, bus.alu_r2, bus.alu_op); end
        n_cmp++; if (bus.resp_valid !== 2'b00) begin n_bad++; $display("FAIL add_exec_resp_valid got=%b exp=00", bus.resp_valid); end
        @(negedge clk);
        n_cmp++; if (bus.resp_valid !== 2'b01) begin n_bad++; $display("FAIL add_resp_valid got=%b exp=01", bus.resp_valid); end
        n_cmp++; if (bus.resp_result !== W'(12)) begin n_bad++; $display("FAIL add_result got=%0d exp=12", bus.resp_result); end
        n_cmp++; if (bus.resp_zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got=%b exp=0", bus.resp_zero); end
        bus.resp_ready = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.resp_valid !== 2'b00) begin
            n_bad++; $display("FAIL add_release got busy=%b rv=%b exp busy=0 rv=00", bus.busy, bus.resp_valid); end
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_eq();
        bit ok; logic [1:0] rdy, rv; logic [W-1:0] res; logic z;
        send(1, W'(32'h1234), W'(32'h1234), ALU_OP_EQ, ok, rdy, rv, res, z);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL eq_same_timeout got=%b exp=1", ok); end
        n_cmp++; if (rdy !== 2'b10 || rv !== 2'b10) begin n_bad++; $display("FAIL eq_same_ports got rdy=%b rv=%b exp=10/10", rdy, rv); end
        n_cmp++; if (res !== W'(1) || z !== 1'b0) begin n_bad++; $display("FAIL eq_same_result got=%h z=%b exp=1 z=0", res, z); end
        send(1, W'(32'h1234), W'(32'h1235), ALU_OP_EQ, ok, rdy, rv, res, z);
        n_cmp++; if (ok !== 1'b1 || rv !== 2'b10) begin n_bad++; $display("FAIL eq_diff_resp got ok=%b rv=%b exp=1/10", ok, rv); end
        n_cmp++; if (res !== W'(0) || z !== 1'b1) begin n_bad++; $display("FAIL eq_diff_result got=%h z=%b exp=0 z=1", res, z); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a[2], b[2];
        logic [O-1:0] op[2];
        logic [W-1:0] pend_res;
        int acc = 0, last = 0, pend_p = 0, acc_port, g;
        bit ok;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            a[p] = $urandom; b[p] = $urandom; op[p] = O'($urandom_range(0, 3));
            drive_port(p, a[p], b[p], op[p]);
        end
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            @(negedge clk);
            acc_port = -1;
            if (bus.resp_valid != 2'b00) begin
                n_cmp++; if (bus.resp_valid !== oh(pend_p) || bus.resp_result !== pend_res) begin
                    n_bad++; $display("FAIL b2b_resp got rv=%b res=%h exp rv=%b res=%h", bus.resp_valid, bus.resp_result, oh(pend_p), pend_res); end
            end
            if (bus.req_ready != 2'b00) begin
                g = model_grant(2'b11);
                n_cmp++; if (bus.req_ready !== oh(g)) begin n_bad++; $display("FAIL b2b_grant#%0d got=%b exp=%b", acc, bus.req_ready, oh(g)); end
                if (acc > 0) begin
                    n_cmp++; if (c - last != 3) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=3", c - last); end
                end
                last = c; acc++; pend_p = g; acc_port = g;
                pend_res = ref_alu(op[g], a[g], b[g]);
                note_accept(g);
            end
            @(posedge clk); #1;
            if (acc_port >= 0) begin
                a[acc_port] = $urandom; b[acc_port] = $urandom; op[acc_port] = O'($urandom_range(0, 3));
                drive_port(acc_port, a[acc_port], b[acc_port], op[acc_port]);
            end
        end
        bus.req_valid = 2'b00;
        n_cmp++; if (acc != 6) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=6", acc); end
        wait_resp(ok);
        n_cmp++; if (!ok || bus.resp_valid !== oh(pend_p) || bus.resp_result !== pend_res) begin
            n_bad++; $display("FAIL b2b_last_resp got ok=%b rv=%b res=%h exp rv=%b res=%h", ok, bus.resp_valid, bus.resp_result, oh(pend_p), pend_res); end
        @(posedge clk); #1;
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b, exp;
        bit ok;
        a = $urandom; b = $urandom; exp = a + b;
        @(posedge clk); #1;
        drive_port(0, a, b, ALU_OP_ADD);
        bus.req_valid = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL stall_req_ready got=%b exp=01", bus.req_ready); end
        @(posedge clk); #1;
        note_accept(0);
        drive_port(1, $urandom, $urandom, ALU_OP_OR);
        bus.req_valid  = 2'b10;
        bus.resp_ready = 2'b10;
        wait_resp(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_timeout got=%b exp=1", ok); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.resp_valid !== 2'b01 || bus.resp_result !== exp || bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold#%0d got rv=%b res=%h rdy=%b busy=%b exp rv=01 res=%h rdy=00 busy=1",
                                  i, bus.resp_valid, bus.resp_result, bus.req_ready, bus.busy, exp); end
            @(negedge clk);
        end
        bus.resp_ready = 2'b01;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
            n_bad++; $display("FAIL stall_release got busy=%b rv=%b rdy=%b exp busy=0 rv=00 rdy=10", bus.busy, bus.resp_valid, bus.req_ready); end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
    endtask

    task automatic test_rst_mid();
        bit ok; logic [1:0] rdy, rv; logic [W-1:0] a, b, res; logic z;
        int seen = 0;
        @(posedge clk); #1;
        drive_port(1, $urandom | 1, $urandom | 1, ALU_OP_OR);
        bus.req_valid = 2'b10;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1 || bus.alu_r1 === '0) begin n_bad++; $display("FAIL rst_mid_exec got busy=%b r1=%h exp busy=1 r1!=0", bus.busy, bus.alu_r1); end
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_pref = 0;
`endif
        bus.resp_ready = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen); end
        bus.resp_ready = 2'b00;
        a = $urandom; b = $urandom;
        send(1, a, b, ALU_OP_AND, ok, rdy, rv, res, z);
        n_cmp++; if (!ok || rdy !== 2'b10 || rv !== 2'b10 || res !== (a & b) || z !== ((a & b) == '0)) begin
            n_bad++; $display("FAIL rst_mid_after got ok=%b rdy=%b rv=%b res=%h exp rdy=10 rv=10 res=%h", ok, rdy, rv, res, a & b); end
    endtask

    task automatic test_random();
        logic [W-1:0] a[2], b[2], exp;
        logic [O-1:0] op[2];
        logic [1:0] mask;
        int g, stall;
        bit ok;
        for (int it = 0; it < 24; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                a[p] = $urandom;
                b[p] = ($urandom_range(0, 2) == 0) ? a[p] : W'($urandom);
                op[p] = O'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
            drive_port(0, a[0], b[0], op[0]);
            drive_port(1, a[1], b[1], op[1]);
            bus.req_valid = mask;
            @(negedge clk);
            g = model_grant(mask);
            exp = ref_alu(op[g], a[g], b[g]);
            n_cmp++; if (bus.req_ready !== oh(g)) begin n_bad++; $display("FAIL rnd_grant#%0d mask=%b got=%b exp=%b", it, mask, bus.req_ready, oh(g)); end
            @(posedge clk); #1;
            bus.req_valid = 2'b00;
            note_accept(g);
            wait_resp(ok);
            n_cmp++; if (!ok || bus.resp_valid !== oh(g) || bus.resp_result !== exp || bus.resp_zero !== (exp == '0)) begin
                n_bad++; $display("FAIL rnd_resp#%0d got ok=%b rv=%b res=%h z=%b exp rv=%b res=%h z=%b",
                                  it, ok, bus.resp_valid, bus.resp_result, bus.resp_zero, oh(g), exp, exp == '0); end
            stall = $urandom_range(0, 3);
            bus.resp_ready = oh(1 - g);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                n_cmp++; if (bus.resp_valid !== oh(g) || bus.resp_result !== exp) begin
                    n_bad++; $display("FAIL rnd_hold#%0d got rv=%b res=%h exp rv=%b res=%h", it, bus.resp_valid, bus.resp_result, oh(g), exp); end
            end
            bus.resp_ready = oh(g);
            @(posedge clk); #1;
            bus.resp_ready = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_eq();
        test_back_to_back();
        test_stall();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
